// File: rtl/ap_add_seq.sv
// ap_add_seq: bit-serial B <= A + B sequencer driving CAM compare/tag-write.
// Build option AP_SEQ_SKIP_EMPTY_EN drops write cycles with empty tag vectors.
module ap_add_seq #(
    parameter int WORD_SIZE  = 9,
    parameter int CELL_QUANT = 512,
    parameter int OP_W       = 4
) (
    input  logic                  CLK100MHZ,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [WORD_SIZE-1:0]  key,
    output logic [WORD_SIZE-1:0]  mask,
    output logic [WORD_SIZE-1:0]  dina,
    output logic                  cam_mode,
    output logic [CELL_QUANT-1:0] cell_wea_ctrl_ap,
    input  logic [CELL_QUANT-1:0] tags
);

    localparam int BW = (OP_W > 1) ? $clog2(OP_W) : 1;
    localparam int C_POS = 2 * OP_W;
    localparam logic [BW-1:0] LAST_BIT = BW'(OP_W - 1);
    localparam logic [2:0] LAST_PASS = 3'd4;
    localparam logic [WORD_SIZE-1:0] ONE = WORD_SIZE'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR_CMP,
        S_CLR_WR,
        S_CMP,
        S_WR,
        S_DONE
    } state_t;

    state_t state, state_nx;
    logic [BW-1:0] bit_i;
    logic [2:0] pass_p;
    logic [CELL_QUANT-1:0] tag_q;
    logic last;
    logic skip;
    logic [2:0] pat;
    logic [1:0] wr;
    logic [WORD_SIZE-1:0] a_sel;
    logic [WORD_SIZE-1:0] b_sel;
    logic [WORD_SIZE-1:0] c_sel;

    assign last = (bit_i == LAST_BIT) && (pass_p == LAST_PASS);

`ifdef AP_SEQ_SKIP_EMPTY_EN
    assign skip = (tags == '0);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge CLK100MHZ) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rst) begin
            tag_q  <= '0;
            bit_i  <= '0;
            pass_p <= '0;
        end else begin
            if (state == S_CLR_CMP || state == S_CMP)
                tag_q <= tags;
            if (state == S_WR || (state == S_CMP && skip)) begin
                if (pass_p == LAST_PASS) begin
                    pass_p <= '0;
                    bit_i  <= (bit_i == LAST_BIT) ? '0 : bit_i + 1'b1;
                end else begin
                    pass_p <= pass_p + 3'd1;
                end
            end else if (state != S_CMP) begin
                pass_p <= '0;
                bit_i  <= '0;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (start) state_nx = S_CLR_CMP;
            S_CLR_CMP: state_nx = skip ? S_CMP : S_CLR_WR;
            S_CLR_WR:  state_nx = S_CMP;
            S_CMP: begin
                if (!skip)     state_nx = S_WR;
                else if (last) state_nx = S_DONE;
                else           state_nx = S_CMP;
            end
            S_WR:      state_nx = last ? S_DONE : S_CMP;
            S_DONE:    state_nx = S_IDLE;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Pass order matters: no row's rewritten pattern matches a later pass.
    always_comb begin
        pat = 3'b001;
        wr  = 2'b01;
        unique case (pass_p)
            3'd0:    begin pat = 3'b100; wr = 2'b01; end
            3'd1:    begin pat = 3'b110; wr = 2'b10; end
            3'd2:    begin pat = 3'b101; wr = 2'b10; end
            3'd3:    begin pat = 3'b011; wr = 2'b10; end
            default: begin pat = 3'b001; wr = 2'b01; end
        endcase
    end

    assign a_sel = ONE << bit_i;
    assign b_sel = a_sel << OP_W;
    assign c_sel = ONE << C_POS;

    always_comb begin
        busy             = 1'b1;
        done             = 1'b0;
        key              = '0;
        mask             = '0;
        dina             = '0;
        cam_mode         = 1'b0;
        cell_wea_ctrl_ap = '0;
        unique case (state)
            S_IDLE: busy = 1'b0;
            S_CLR_CMP: begin
                mask = c_sel;
                key  = c_sel;
            end
            S_CLR_WR: begin
                cam_mode         = 1'b1;
                cell_wea_ctrl_ap = tag_q;
                mask             = c_sel;
            end
            S_CMP: begin
                mask = c_sel | b_sel | a_sel;
                key  = ({WORD_SIZE{pat[2]}} & c_sel)
                     | ({WORD_SIZE{pat[1]}} & b_sel)
                     | ({WORD_SIZE{pat[0]}} & a_sel);
            end
            S_WR: begin
                cam_mode         = 1'b1;
                cell_wea_ctrl_ap = tag_q;
                mask             = c_sel | b_sel;
                dina             = ({WORD_SIZE{wr[1]}} & c_sel)
                                 | ({WORD_SIZE{wr[0]}} & b_sel);
            end
            S_DONE: done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_ap_add_seq.sv
// tb_ap_add_seq: random and directed checks of ap_add_seq against a
// behavioural CAM and an arithmetic reference for sums and latency.
module tb_ap_add_seq;

    localparam int W  = 9;
    localparam int N  = 4;
    localparam int OW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy;
    logic done;
    logic [W-1:0] key;
    logic [W-1:0] mask;
    logic [W-1:0] dina;
    logic cam_mode;
    logic [N-1:0] cell_wea_ctrl_ap;
    logic [N-1:0] tags;

    logic [W-1:0] cam [N];
    logic [W-1:0] ld_data [N];
    logic ld_en = 1'b0;
    logic [W-1:0] pre [N];

    int n_tests = 0;
    int n_fail = 0;
    int done_at, n_done, busy_cycles, busy_first, idle_at, wea_bad;

    always #5 clk = ~clk;

    ap_add_seq #(
        .WORD_SIZE(W),
        .CELL_QUANT(N),
        .OP_W(OW)
    ) dut (
        .CLK100MHZ(clk),
        .rst(rst),
        .start(start),
        .busy(busy),
        .done(done),
        .key(key),
        .mask(mask),
        .dina(dina),
        .cam_mode(cam_mode),
        .cell_wea_ctrl_ap(cell_wea_ctrl_ap),
        .tags(tags)
    );

    // Behavioural CAM: combinational match, tag-guided masked write.
    always_comb begin
        tags = '0;
        for (int r = 0; r < N; r++)
            tags[r] = (((cam[r] ^ key) & mask) == '0);
    end

    always @(posedge clk) begin
        if (ld_en) begin
            for (int r = 0; r < N; r++) cam[r] <= ld_data[r];
        end else if (cam_mode) begin
            for (int r = 0; r < N; r++)
                if (cell_wea_ctrl_ap[r])
                    cam[r] <= (cam[r] & ~mask) | (dina & mask);
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mkw(input int c, input int b,
                                         input int a);
        return {c[0], b[3:0], a[3:0]};
    endfunction

    function automatic logic [W-1:0] ref_sum(input logic [W-1:0] w);
        int s;
        s = int'(w[OW-1:0]) + int'(w[2*OW-1:OW]);
        return {s[OW], s[OW-1:0], w[OW-1:0]};
    endfunction

    function automatic int exp_lat();
`ifdef AP_SEQ_SKIP_EMPTY_EN
        int lat;
        int pats [5];
        int a, b, m, c, pc;
        bit hit;
        pats = '{4, 6, 5, 3, 1};
        lat = 2;
        hit = 0;
        for (int r = 0; r < N; r++) if (pre[r][2*OW]) hit = 1;
        if (hit) lat++;
        for (int i = 0; i < OW; i++) begin
            for (int p = 0; p < 5; p++) begin
                hit = 0;
                for (int r = 0; r < N; r++) begin
                    a = int'(pre[r][OW-1:0]);
                    b = int'(pre[r][2*OW-1:OW]);
                    m = (1 << i) - 1;
                    c = ((a & m) + (b & m)) >> i;
                    pc = (c << 2) | (((b >> i) & 1) << 1) | ((a >> i) & 1);
                    if (pc == pats[p]) hit = 1;
                end
                lat += 1 + int'(hit);
            end
        end
        return lat;
`else
        return 10 * OW + 3;
`endif
    endfunction

    task automatic load(input logic [W-1:0] w0, input logic [W-1:0] w1,
                        input logic [W-1:0] w2, input logic [W-1:0] w3);
        @(negedge clk);
        ld_data[0] = w0;
        ld_data[1] = w1;
        ld_data[2] = w2;
        ld_data[3] = w3;
        ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
        for (int r = 0; r < N; r++) pre[r] = cam[r];
    endtask

    task automatic check_idle(input string tag);
        check($sformatf("%s.busy", tag), 32'(busy), 0);
        check($sformatf("%s.done", tag), 32'(done), 0);
        check($sformatf("%s.key", tag), 32'(key), 0);
        check($sformatf("%s.mask", tag), 32'(mask), 0);
        check($sformatf("%s.dina", tag), 32'(dina), 0);
        check($sformatf("%s.mode", tag), 32'(cam_mode), 0);
        check($sformatf("%s.wea", tag), 32'(cell_wea_ctrl_ap), 0);
    endtask

    task automatic run_op(input int p1, input int p2, input int rst_at);
        done_at = -1;
        n_done = 0;
        busy_cycles = 0;
        busy_first = -1;
        idle_at = -1;
        wea_bad = 0;
        @(negedge clk);
        start = 1'b1;
        for (int j = 1; j <= 200; j++) begin
            @(negedge clk);
            if (busy) begin
                busy_cycles++;
                if (busy_first < 0) busy_first = j;
            end
            if (done) begin
                n_done++;
                if (done_at < 0) done_at = j;
            end
            if (cell_wea_ctrl_ap != '0 && !cam_mode) wea_bad++;
            start = (j == p1) || (j == p2);
            rst = !(j == rst_at);
            if (rst_at > 0 && j == rst_at + 1) begin
                check_idle("rst");
                break;
            end
            if (!busy && done_at > 0) begin
                idle_at = j;
                break;
            end
        end
        start = 1'b0;
        rst = 1'b1;
    endtask

    task automatic check_run(input string tag);
        int lat;
        lat = exp_lat();
        check($sformatf("%s.done_at", tag), 32'(done_at), 32'(lat));
        check($sformatf("%s.n_done", tag), 32'(n_done), 1);
        check($sformatf("%s.busy_rise", tag), 32'(busy_first), 1);
        check($sformatf("%s.idle_at", tag), 32'(idle_at), 32'(lat + 1));
        check($sformatf("%s.busy_cyc", tag), 32'(busy_cycles), 32'(lat));
        check($sformatf("%s.wea_bad", tag), 32'(wea_bad), 0);
        for (int r = 0; r < N; r++)
            check($sformatf("%s.row%0d", tag, r), 32'(cam[r]),
                  32'(ref_sum(pre[r])));
    endtask

    initial begin
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b1;

        load(mkw(1, 5, 3), mkw(1, 1, 15), mkw(1, 0, 0), mkw(1, 6, 9));
        run_op(0, 0, 0);
        check_run("basic");

        load(mkw(1, 5, 3), mkw(1, 1, 15), mkw(1, 0, 0), mkw(1, 6, 9));
        run_op(5, 20, 0);
        check_run("busy_start");

        load(mkw(1, 5, 3), mkw(1, 1, 15), mkw(1, 0, 0), mkw(1, 6, 9));
        run_op(0, 0, 15);
        for (int r = 0; r < N; r++) pre[r] = cam[r];
        run_op(0, 0, 0);
        check_run("after_rst");

        load(mkw(0, 0, 0), mkw(0, 0, 0), mkw(0, 0, 0), mkw(0, 0, 0));
        run_op(0, 0, 0);
        check_run("zeros");

        load(mkw(0, 15, 15), mkw(0, 15, 15), mkw(0, 15, 15),
             mkw(0, 15, 15));
        run_op(0, 0, 0);
        check_run("all15");

        for (int it = 0; it < 6; it++) begin
            load(W'($urandom_range(0, 511)), W'($urandom_range(0, 511)),
                 W'($urandom_range(0, 511)), W'($urandom_range(0, 511)));
            run_op(0, 0, 0);
            check_run($sformatf("rand%0d", it));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
